rr_grant_ctrl: RTL and testbench
================================

# rr_grant_ctrl

Round-robin grant controller that shares one resource among `REQCNT` requesters with multi-cycle ownership. A requester holds the grant until it signals `done_i`, drops its request, or hits a hold-time limit. Ownership then rotates fairly. It sits in front of the shared datapath, and its `gnt_num_o` drives that datapath's input mux select.

## Interface
Parameters:
- `REQCNT`, 5: number of requesters; any value ≥ 2, power of two not required.
- `REQWIDTH`, `$clog2(REQCNT)`: width of the requester index.
- `MAXHOLD`, 16: maximum consecutive grant cycles per ownership; ≥ 1.
- `HOLDWIDTH`, `$clog2(MAXHOLD)` (minimum 1): hold counter width.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `req_i` in `REQCNT`: request vector; bit i = requester i wants the resource.
- `done_i` in 1: current owner finished; sampled only in GRANT.
- `gnt_o` out `REQCNT`: one-hot grant, registered.
- `gnt_num_o` out `REQWIDTH`: index of the owner, registered; valid when `gnt_val_o`=1.
- `gnt_val_o` out 1: a grant is active (equals `|gnt_o`).
- `timeout_o` out 1: one-cycle pulse when a grant is force-released by `MAXHOLD`.

## Operation
- State machine with three states: IDLE, GRANT, GAP.
- Internal registers:
  - `ptr` is the search start index, reset 0.
  - `owner` has width `REQWIDTH`.
  - `hold_cnt` has width `HOLDWIDTH`.
- Arbitration runs in IDLE and in GAP:
  - Search `req_i` starting at `ptr`, ascending, wrapping from `REQCNT-1` to 0.
  - The first set bit wins.
  - If `req_i`=0, stay in IDLE (GAP goes to IDLE).
- On a win: `owner` takes the winning index, `hold_cnt` is set to 0, state goes to GRANT, and `gnt_o`/`gnt_num_o`/`gnt_val_o` reflect the winner.
- In GRANT, at each edge the release conditions are evaluated in this priority order:
  1. `done_i`=1: normal release.
  2. `req_i[owner]`=0: requester withdrew; normal release.
  3. `hold_cnt`=`MAXHOLD-1`: forced release; `timeout_o`=1 for the next cycle.
  4. Otherwise: `hold_cnt` += 1 and stay in GRANT.
- On any release:
  - `ptr` = `owner`+1, wrapping to 0 when `owner`=`REQCNT-1`.
  - Grant outputs clear to 0 and state goes to GAP.
- GAP lasts exactly one cycle with no grant, which is the handover dead cycle. Arbitration at the end of GAP uses the updated `ptr`.
- Consequences of the rotation:
  - The just-released owner is searched last, so it is re-granted only if no other requester is active.
  - `done_i` outside GRANT is ignored.
  - `req_i` changes during GRANT for non-owners have no effect until the next arbitration.
- `gnt_o` is never multi-hot; `gnt_num_o` is 0 whenever `gnt_val_o`=0.

## Timing
- Reset:
  - All outputs 0 immediately on `rst_i` rising, without waiting for a clock.
  - State goes to IDLE; `ptr`, `owner` and `hold_cnt` go to 0.
  - Reset mid-grant drops the grant in the same cycle, and no `timeout_o` is produced.
- Grant latency: a request present at edge E while in IDLE gives grant outputs valid after E, i.e. a 1-cycle latency.
- Grant duration:
  - With `done_i` first seen high at the k-th GRANT edge, the grant is visible for k cycles.
  - The maximum is `MAXHOLD` cycles.
- Back-to-back: between two grants there is exactly one cycle with `gnt_val_o`=0 (the GAP cycle).
- `timeout_o` is high during the GAP cycle that follows a forced release, and only then.
- Simultaneous events:
  - `done_i` and the limit on the same edge give a normal release with no timeout.
  - Withdraw and the limit on the same edge give a normal release with no timeout.
- Throughput: with all requesters active and `done_i` held high, each requester gets 1 grant cycle every 2·`REQCNT` cycles.

## Test plan
- Reset check: assert `rst_i` mid-simulation between edges. Required: `gnt_o`=0, `gnt_val_o`=0, `gnt_num_o`=0 and `timeout_o`=0 without waiting for a clock edge. After release, `req_i`=5'b10001 grants index 0 first.
- Single requester: `req_i`=5'b00100, `done_i` pulsed at the 3rd GRANT edge. Required: `gnt_o`=5'b00100 and `gnt_num_o`=2 for exactly 3 cycles, then 1 GAP cycle, then re-grant to 2 if still requesting.
- Full rotation: `req_i`=5'b11111, `done_i`=1 constant. Required: `gnt_num_o` sequence 0,1,2,3,4,0, each granted 1 cycle and separated by 1 GAP cycle.
- Timeout: `MAXHOLD`=16, `req_i`=5'b01010, `done_i`=0. Required:
  - index 1 is granted exactly 16 cycles;
  - `timeout_o`=1 for 1 cycle;
  - then index 3 is granted for 16 cycles and index 1 follows.
- Wrap and withdraw: last owner 4 releases, then `req_i`=5'b00011. Required: grant goes to 0, not 1. Dropping `req_i[0]` mid-grant releases with no timeout, and 1 is granted after the GAP.
- Simultaneous release: `done_i` rises on the same edge that `hold_cnt` reaches 15. Required: normal release and `timeout_o` stays 0.

Source files
------------

// File: rtl/rr_grant_ctrl.sv
// -----------------------------------------------------------------------------
// rr_grant_ctrl
//
// Round-robin grant controller sharing one resource among REQCNT requesters.
// An owner keeps the grant for several cycles until it signals done, drops
// its request, or reaches the MAXHOLD hold limit. Ownership then rotates:
// the next search starts just after the released owner. A one-cycle GAP with
// no grant separates consecutive ownerships.
//
// Ports:
//   clk_i      in  1         clock, rising edge
//   rst_i      in  1         asynchronous active-high reset
//   req_i      in  REQCNT    request vector, bit i = requester i
//   done_i     in  1         current owner finished (used only in GRANT)
//   gnt_o      out REQCNT    one-hot grant, registered
//   gnt_num_o  out REQWIDTH  owner index, registered, 0 when no grant
//   gnt_val_o  out 1         a grant is active, registered
//   timeout_o  out 1         one-cycle pulse in the GAP after a forced release
// -----------------------------------------------------------------------------
module rr_grant_ctrl #(
    parameter int REQCNT    = 5,
    parameter int REQWIDTH  = $clog2(REQCNT),
    parameter int MAXHOLD   = 16,
    parameter int HOLDWIDTH = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [REQCNT-1:0]   req_i,
    input  logic                done_i,
    output logic [REQCNT-1:0]   gnt_o,
    output logic [REQWIDTH-1:0] gnt_num_o,
    output logic                gnt_val_o,
    output logic                timeout_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [REQWIDTH:0]    REQCNT_W  = (REQWIDTH + 1)'(REQCNT);
    localparam logic [HOLDWIDTH-1:0] HOLD_LAST = HOLDWIDTH'(MAXHOLD - 1);

    // Modulo-REQCNT addition; operands are both below REQCNT, so one
    // conditional subtraction is enough even when REQCNT is not a power of two.
    function automatic logic [REQWIDTH-1:0] wrap_add(
        input logic [REQWIDTH-1:0] base,
        input logic [REQWIDTH-1:0] offs
    );
        logic [REQWIDTH:0] sum;
        sum = {1'b0, base} + {1'b0, offs};
        if (sum >= REQCNT_W) begin
            sum = sum - REQCNT_W;
        end else begin
            sum = sum;
        end
        return sum[REQWIDTH-1:0];
    endfunction

    // State and datapath registers
    logic [1:0]           r_state;
    logic [REQWIDTH-1:0]  r_ptr;
    logic [REQWIDTH-1:0]  r_owner;
    logic [HOLDWIDTH-1:0] r_hold_cnt;
    logic [REQCNT-1:0]    r_gnt;
    logic [REQWIDTH-1:0]  r_gnt_num;
    logic                 r_gnt_val;
    logic                 r_timeout;

    // Next-state values
    logic [1:0]           w_state_nxt;
    logic [REQWIDTH-1:0]  w_ptr_nxt;
    logic [REQWIDTH-1:0]  w_owner_nxt;
    logic [HOLDWIDTH-1:0] w_hold_cnt_nxt;
    logic [REQCNT-1:0]    w_gnt_nxt;
    logic [REQWIDTH-1:0]  w_gnt_num_nxt;
    logic                 w_gnt_val_nxt;
    logic                 w_timeout_nxt;

    // Arbitration and release decode
    logic                 w_arb_found;
    logic [REQWIDTH-1:0]  w_arb_idx;
    logic [REQWIDTH-1:0]  w_scan_idx;
    logic                 w_release_normal;
    logic                 w_release_force;

    // Rotating priority search: first set request at or after r_ptr wins.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = {REQWIDTH{1'b0}};
        w_scan_idx  = {REQWIDTH{1'b0}};
        for (int i = 0; i < REQCNT; i++) begin
            w_scan_idx = wrap_add(r_ptr, REQWIDTH'(i));
            if (!w_arb_found && req_i[w_scan_idx]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_scan_idx;
            end else begin
                w_arb_found = w_arb_found;
                w_arb_idx   = w_arb_idx;
            end
        end
    end

    // Release decode; done and withdraw outrank the hold limit, so a
    // coincident limit never produces a timeout pulse.
    always_comb begin
        w_release_normal = done_i | ~req_i[r_owner];
        w_release_force  = ~w_release_normal & (r_hold_cnt == HOLD_LAST);
    end

    // Next-state and next-output logic for the IDLE / GRANT / GAP machine.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_owner_nxt    = r_owner;
        w_hold_cnt_nxt = r_hold_cnt;
        w_gnt_nxt      = r_gnt;
        w_gnt_num_nxt  = r_gnt_num;
        w_gnt_val_nxt  = r_gnt_val;
        w_timeout_nxt  = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_arb_found) begin
                    w_state_nxt    = ST_GRANT;
                    w_owner_nxt    = w_arb_idx;
                    w_hold_cnt_nxt = {HOLDWIDTH{1'b0}};
                    w_gnt_nxt      = REQCNT'(1) << w_arb_idx;
                    w_gnt_num_nxt  = w_arb_idx;
                    w_gnt_val_nxt  = 1'b1;
                end else begin
                    w_state_nxt   = ST_IDLE;
                    w_gnt_nxt     = {REQCNT{1'b0}};
                    w_gnt_num_nxt = {REQWIDTH{1'b0}};
                    w_gnt_val_nxt = 1'b0;
                end
            end
            ST_GRANT: begin
                if (w_release_normal || w_release_force) begin
                    w_state_nxt   = ST_GAP;
                    // The released owner becomes the last one searched.
                    w_ptr_nxt     = wrap_add(r_owner, REQWIDTH'(1));
                    w_gnt_nxt     = {REQCNT{1'b0}};
                    w_gnt_num_nxt = {REQWIDTH{1'b0}};
                    w_gnt_val_nxt = 1'b0;
                    w_timeout_nxt = w_release_force;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLDWIDTH'(1);
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_ptr_nxt      = {REQWIDTH{1'b0}};
                w_owner_nxt    = {REQWIDTH{1'b0}};
                w_hold_cnt_nxt = {HOLDWIDTH{1'b0}};
                w_gnt_nxt      = {REQCNT{1'b0}};
                w_gnt_num_nxt  = {REQWIDTH{1'b0}};
                w_gnt_val_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears grants without a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_ptr      <= {REQWIDTH{1'b0}};
            r_owner    <= {REQWIDTH{1'b0}};
            r_hold_cnt <= {HOLDWIDTH{1'b0}};
            r_gnt      <= {REQCNT{1'b0}};
            r_gnt_num  <= {REQWIDTH{1'b0}};
            r_gnt_val  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_num  <= w_gnt_num_nxt;
            r_gnt_val  <= w_gnt_val_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign gnt_o     = r_gnt;
    assign gnt_num_o = r_gnt_num;
    assign gnt_val_o = r_gnt_val;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rr_grant_ctrl
//
// Directed bench for rr_grant_ctrl (REQCNT=5, MAXHOLD=16). A vector table
// covers single-requester grants, rotation, wrap and withdraw; hand-written
// sequences cover asynchronous reset, hold-limit timeout and the coincident
// done/limit release.
// -----------------------------------------------------------------------------
module tb_rr_grant_ctrl;

    logic       clk_i;
    logic       rst_i;
    logic [4:0] req_i;
    logic       done_i;
    logic [4:0] gnt_o;
    logic [2:0] gnt_num_o;
    logic       gnt_val_o;
    logic       timeout_o;

    int n_checks;
    int n_errors;

    rr_grant_ctrl #(
        .REQCNT  (5),
        .MAXHOLD (16)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .done_i    (done_i),
        .gnt_o     (gnt_o),
        .gnt_num_o (gnt_num_o),
        .gnt_val_o (gnt_val_o),
        .timeout_o (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0] req;
        logic       done;
        logic [4:0] gnt;
        logic [2:0] num;
        logic       val;
        logic       tmo;
    } vec_t;

    vec_t vecs[30];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [4:0] g, input logic [2:0] n,
                             input logic v, input logic t);
        check({tag, " gnt_o"},     int'(gnt_o),     int'(g));
        check({tag, " gnt_num_o"}, int'(gnt_num_o), int'(n));
        check({tag, " gnt_val_o"}, int'(gnt_val_o), int'(v));
        check({tag, " timeout_o"}, int'(timeout_o), int'(t));
    endtask

    // Drive inputs (we sit at a falling edge), take one rising edge, return
    // at the following falling edge where outputs are sampled.
    task automatic tick(input logic [4:0] r, input logic d);
        req_i  = r;
        done_i = d;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_i  = 1'b1;
        req_i  = 5'b00000;
        done_i = 1'b0;

        // Table: inputs before an edge, expected outputs after it.
        vecs[0]  = '{5'b10001, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b0}; // win 0 from ptr 0
        vecs[1]  = '{5'b10001, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0}; // done -> GAP
        vecs[2]  = '{5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0}; // GAP -> IDLE
        vecs[3]  = '{5'b00100, 1'b0, 5'b00100, 3'd2, 1'b1, 1'b0}; // grant 2
        vecs[4]  = '{5'b00100, 1'b0, 5'b00100, 3'd2, 1'b1, 1'b0};
        vecs[5]  = '{5'b00100, 1'b0, 5'b00100, 3'd2, 1'b1, 1'b0};
        vecs[6]  = '{5'b00100, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0}; // done at 3rd edge
        vecs[7]  = '{5'b00100, 1'b0, 5'b00100, 3'd2, 1'b1, 1'b0}; // re-grant 2
        vecs[8]  = '{5'b11111, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0}; // ptr -> 3
        vecs[9]  = '{5'b11111, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b0};
        vecs[10] = '{5'b11111, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0};
        vecs[11] = '{5'b11111, 1'b1, 5'b10000, 3'd4, 1'b1, 1'b0};
        vecs[12] = '{5'b11111, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0};
        vecs[13] = '{5'b11111, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b0};
        vecs[14] = '{5'b11111, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0};
        vecs[15] = '{5'b11111, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b0};
        vecs[16] = '{5'b11111, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0};
        vecs[17] = '{5'b11111, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b0};
        vecs[18] = '{5'b11111, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0};
        vecs[19] = '{5'b11111, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b0};
        vecs[20] = '{5'b11111, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0};
        vecs[21] = '{5'b11111, 1'b1, 5'b10000, 3'd4, 1'b1, 1'b0}; // owner 4
        vecs[22] = '{5'b00011, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0}; // ptr wraps to 0
        vecs[23] = '{5'b00011, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b0}; // 0, not 1
        vecs[24] = '{5'b00011, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b0};
        vecs[25] = '{5'b00010, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0}; // withdraw, no timeout
        vecs[26] = '{5'b00010, 1'b0, 5'b00010, 3'd1, 1'b1, 1'b0};
        vecs[27] = '{5'b00010, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0};
        vecs[28] = '{5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0}; // done ignored in GAP
        vecs[29] = '{5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0}; // done ignored in IDLE

        // Reset state, held across clock edges
        @(posedge clk_i);
        @(negedge clk_i);
        check_all("reset", 5'b00000, 3'd0, 1'b0, 1'b0);
        rst_i = 1'b0;

        for (int i = 0; i < 30; i++) begin
            tick(vecs[i].req, vecs[i].done);
            check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].num, vecs[i].val, vecs[i].tmo);
        end

        // Asynchronous reset mid-grant; ptr is currently 2 so index 2 wins
        tick(5'b00100, 1'b0);
        check_all("pre_rst", 5'b00100, 3'd2, 1'b1, 1'b0);
        #2 rst_i = 1'b1;
        #1 check_all("async_rst", 5'b00000, 3'd0, 1'b0, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        // After reset ptr is 0 again: 10001 grants index 0 first
        tick(5'b10001, 1'b0);
        check_all("post_rst", 5'b00001, 3'd0, 1'b1, 1'b0);
        tick(5'b10001, 1'b1);
        check_all("post_rst_rel", 5'b00000, 3'd0, 1'b0, 1'b0);
        tick(5'b00000, 1'b0);
        rst_i = 1'b1;
        #1 rst_i = 1'b0;

        // Timeout: 01010 from ptr 0 -> index 1 for 16 cycles, pulse, index 3, pulse, index 1
        for (int c = 0; c < 16; c++) begin
            tick(5'b01010, 1'b0);
            check_all($sformatf("to_own1_c%0d", c), 5'b00010, 3'd1, 1'b1, 1'b0);
        end
        tick(5'b01010, 1'b0);
        check_all("to_pulse1", 5'b00000, 3'd0, 1'b0, 1'b1);
        for (int c = 0; c < 16; c++) begin
            tick(5'b01010, 1'b0);
            check_all($sformatf("to_own3_c%0d", c), 5'b01000, 3'd3, 1'b1, 1'b0);
        end
        tick(5'b01010, 1'b0);
        check_all("to_pulse2", 5'b00000, 3'd0, 1'b0, 1'b1);
        tick(5'b01010, 1'b0);
        check_all("to_regrant1", 5'b00010, 3'd1, 1'b1, 1'b0);

        // Simultaneous: owner 1 (hold 0); 15 more edges bring hold to 15,
        // then done arrives on the limit edge -> normal release, no pulse.
        for (int c = 0; c < 15; c++) begin
            tick(5'b01010, 1'b0);
            check_all($sformatf("sim_c%0d", c), 5'b00010, 3'd1, 1'b1, 1'b0);
        end
        tick(5'b01010, 1'b1);
        check_all("sim_release", 5'b00000, 3'd0, 1'b0, 1'b0);
        tick(5'b00000, 1'b0);
        check_all("sim_gap_end", 5'b00000, 3'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
